// File: rtl/alu_share_pkg.sv
// Shared constants for the shared-ALU controller: op codes, FSM states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_share_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Two-requester request/response bundle for the shared ALU controller.
// Latency: n/a (wires only).
// Backpressure: req_ready from the slave, rsp_ready from the master.
interface alu_share_ctrl_if #(
  parameter int DATA_W = alu_share_pkg::DATA_W_DEF,
  parameter int OP_W   = alu_share_pkg::OP_W_DEF
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_b1;
  logic [OP_W-1:0]   req_op0;
  logic [OP_W-1:0]   req_op1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_op0, req_op1, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_ctrl_core.sv
// alu_core: purely combinational ALU (AND/OR/ADD/SUB/unsigned SLT), illegal op -> 0 with err.
// Latency: 0 cycles.
// Backpressure: none.
module alu_core #(
  parameter int DATA_W = alu_share_pkg::DATA_W_DEF,
  parameter int OP_W   = alu_share_pkg::OP_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              err_o
);
  import alu_share_pkg::*;

  // Decode the op code; add/sub wrap naturally at DATA_W bits.
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_W'(OP_AND): result_o = a_i & b_i;
      OP_W'(OP_OR):  result_o = a_i | b_i;
      OP_W'(OP_ADD): result_o = a_i + b_i;
      OP_W'(OP_SUB): result_o = a_i - b_i;
      OP_W'(OP_SLT): result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default: begin
        result_o = '0;
        err_o    = 1'b1;
      end
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: arbitrate, capture, execute, hold response (ALU_SHARE_FIXED_PRIO_EN = fixed priority to requester 0).
// Latency: accept at edge N, rsp_valid high after edge N+1; one transaction outstanding.
// Backpressure: response held stable until the granted rsp_ready; req_ready low whenever busy.
module alu_share_ctrl #(
  parameter int DATA_W = alu_share_pkg::DATA_W_DEF,
  parameter int OP_W   = alu_share_pkg::OP_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  alu_share_ctrl_if.slave  bus
);
  import alu_share_pkg::*;

  state_t            state_q, state_d;
  logic              win;
  logic              accept;
  logic [1:0]        req_ready;
  logic              gnt_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_zero_q, rsp_err_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero, alu_err;
`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic              ptr_q;
`endif

  // Pick the winner: a lone requester wins; on a tie, fixed or round-robin priority.
  always_comb begin
    win = 1'b0;
    if (bus.req_valid == 2'b10) begin
      win = 1'b1;
    end else if (bus.req_valid == 2'b11) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~ptr_q;
`endif
    end
  end

  // Next-state and handshake decode; ready is masked during reset.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_n && (bus.req_valid != 2'b00)) begin
          accept    = 1'b1;
          req_ready = win ? 2'b10 : 2'b01;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Capture the winning request and update the last-grant pointer on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_q <= 1'b1;
`endif
    end else if (accept) begin
      gnt_q <= win;
      a_q   <= win ? bus.req_a1  : bus.req_a0;
      b_q   <= win ? bus.req_b1  : bus.req_b0;
      op_q  <= win ? bus.req_op1 : bus.req_op0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      ptr_q <= win;
`endif
    end
  end

  // Register the ALU result in EXEC; it stays put through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_data_q <= alu_res;
      rsp_zero_q <= alu_zero;
      rsp_err_q  <= alu_err;
    end
  end

  alu_core #(.DATA_W(DATA_W), .OP_W(OP_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res),
    .zero_o   (alu_zero),
    .err_o    (alu_err)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl.
module tb_alu_share_ctrl;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   failed;

  alu_share_ctrl_if #(.DATA_W(32), .OP_W(4)) bus ();

  alu_share_ctrl #(.DATA_W(32), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] d;
    logic        z;
    logic        e;
  } vec_t;

  // One transaction with fixed timing; starts and ends at a negedge.
  task automatic txn(input logic [1:0] vld, input logic keep,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                     output logic [1:0] rdy_seen, output logic [1:0] rv_seen,
                     output logic [31:0] d, output logic z, output logic e);
    bus.req_valid = vld;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = op0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = op1;
    #1 rdy_seen = bus.req_ready;
    @(negedge clk);
    if (!keep) bus.req_valid = 2'b00;
    bus.req_a0 = ~a0; bus.req_b0 = 32'h5; bus.req_op0 = 4'b0011;
    bus.req_a1 = ~a1; bus.req_b1 = 32'h9; bus.req_op1 = 4'b0000;
    @(negedge clk);
    #1;
    rv_seen = bus.rsp_valid;
    d = bus.rsp_data; z = bus.rsp_zero; e = bus.rsp_err;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    tests_run++; if (bus.req_ready !== 2'b00) begin failed++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 2'b00) begin failed++; $display("FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 32'h0) begin failed++; $display("FAIL reset_rsp_data: got %h expected 0", bus.rsp_data); end
    tests_run++; if (bus.rsp_zero !== 1'b0) begin failed++; $display("FAIL reset_rsp_zero: got %b expected 0", bus.rsp_zero); end
    tests_run++; if (bus.rsp_err !== 1'b0) begin failed++; $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); end
    tests_run++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    logic [1:0] rdy, rv; logic [31:0] d; logic z, e;
    txn(2'b01, 1'b0, 32'd5, 32'd3, 4'b0010, 32'd0, 32'd0, 4'b0000, rdy, rv, d, z, e);
    tests_run++; if (rdy !== 2'b01) begin failed++; $display("FAIL add_req_ready: got %b expected 01", rdy); end
    tests_run++; if (rv !== 2'b01) begin failed++; $display("FAIL add_rsp_valid: got %b expected 01", rv); end
    tests_run++; if (d !== 32'd8) begin failed++; $display("FAIL add_data: got %h expected 8", d); end
    tests_run++; if (z !== 1'b0) begin failed++; $display("FAIL add_zero: got %b expected 0", z); end
    tests_run++; if (e !== 1'b0) begin failed++; $display("FAIL add_err: got %b expected 0", e); end
    #1;
    tests_run++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin failed++; $display("FAIL add_release: got rv=%b busy=%b expected 00/0", bus.rsp_valid, bus.busy); end
  endtask

  task automatic test_ops();
    vec_t v [7];
    logic [1:0] rdy, rv, exp_oh; logic [31:0] d; logic z, e;
    v[0] = '{1'b0, 32'd7,        32'd7,        4'b0110, 32'h0,        1'b1, 1'b0};
    v[1] = '{1'b1, 32'd0,        32'd1,        4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[2] = '{1'b1, 32'd1,        32'hFFFFFFFF, 4'b0111, 32'h1,        1'b0, 1'b0};
    v[3] = '{1'b0, 32'hFFFFFFFF, 32'd1,        4'b0111, 32'h0,        1'b1, 1'b0};
    v[4] = '{1'b0, 32'hF0F0,     32'hFF00,     4'b0000, 32'hF000,     1'b0, 1'b0};
    v[5] = '{1'b1, 32'h0F,       32'hF0,       4'b0011, 32'hFF,       1'b0, 1'b0};
    v[6] = '{1'b0, 32'hFFFFFFFF, 32'd2,        4'b0010, 32'h1,        1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      exp_oh = v[i].r ? 2'b10 : 2'b01;
      txn(exp_oh, 1'b0, v[i].a, v[i].b, v[i].op, v[i].a, v[i].b, v[i].op, rdy, rv, d, z, e);
      tests_run++; if (rdy !== exp_oh || rv !== exp_oh) begin failed++; $display("FAIL ops%0d_handshake: got rdy=%b rv=%b expected %b", i, rdy, rv, exp_oh); end
      tests_run++; if (d !== v[i].d) begin failed++; $display("FAIL ops%0d_data: got %h expected %h", i, d, v[i].d); end
      tests_run++; if (z !== v[i].z || e !== v[i].e) begin failed++; $display("FAIL ops%0d_flags: got z=%b e=%b expected z=%b e=%b", i, z, e, v[i].z, v[i].e); end
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops [3];
    logic [1:0] rdy, rv; logic [31:0] d; logic z, e;
    ops[0] = 4'b1111; ops[1] = 4'b0001; ops[2] = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      txn(2'b01, 1'b0, 32'h1234, 32'h77, ops[i], 32'd0, 32'd0, 4'b0000, rdy, rv, d, z, e);
      tests_run++; if (rv !== 2'b01) begin failed++; $display("FAIL illegal%0d_rsp_valid: got %b expected 01", i, rv); end
      tests_run++; if (d !== 32'h0 || z !== 1'b1 || e !== 1'b1) begin failed++; $display("FAIL illegal%0d_result: got d=%h z=%b e=%b expected 0/1/1", i, d, z, e); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] rdy, rv, exp_oh; logic [31:0] d, exp_d; logic z, e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_oh = 2'b01;
`else
      exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      exp_d = (exp_oh == 2'b01) ? 32'd11 : 32'd18;
      txn(2'b11, 1'b1, 32'd10, 32'd1, 4'b0010, 32'd20, 32'd2, 4'b0110, rdy, rv, d, z, e);
      tests_run++; if (rdy !== exp_oh) begin failed++; $display("FAIL rr%0d_grant: got %b expected %b", i, rdy, exp_oh); end
      tests_run++; if (rv !== exp_oh) begin failed++; $display("FAIL rr%0d_rsp_valid: got %b expected %b", i, rv, exp_oh); end
      tests_run++; if (d !== exp_d) begin failed++; $display("FAIL rr%0d_data: got %h expected %h", i, d, exp_d); end
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_stall();
    bus.req_valid = 2'b01;
    bus.req_a0 = 32'h1234; bus.req_b0 = 32'h0F0F; bus.req_op0 = 4'b0010;
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_a1 = 32'h3; bus.req_b1 = 32'h4; bus.req_op1 = 4'b0010;
    bus.req_a0 = 32'h0; bus.req_op0 = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== 32'h2143 || bus.rsp_zero !== 1'b0 ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 2'b00 || bus.busy !== 1'b1) begin
        failed++;
        $display("FAIL stall%0d: got rv=%b d=%h z=%b e=%b rdy=%b busy=%b expected 01/2143/0/0/00/1",
                 i, bus.rsp_valid, bus.rsp_data, bus.rsp_zero, bus.rsp_err, bus.req_ready, bus.busy);
      end
      bus.rsp_ready = (i % 2 == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    #1;
    tests_run++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin failed++; $display("FAIL stall_release: got rv=%b busy=%b expected 00/0", bus.rsp_valid, bus.busy); end
    tests_run++; if (bus.req_ready !== 2'b10) begin failed++; $display("FAIL stall_pending_ready: got %b expected 10", bus.req_ready); end
    bus.req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bus.req_valid = 2'b11;
    bus.req_a0 = 32'd9; bus.req_b0 = 32'd9; bus.req_op0 = 4'b0010;
    bus.req_a1 = 32'd9; bus.req_b1 = 32'd9; bus.req_op1 = 4'b0010;
    @(negedge clk);
    #1;
    tests_run++; if (bus.busy !== 1'b1) begin failed++; $display("FAIL mid_busy_before: got %b expected 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.busy !== 1'b0 || bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin failed++; $display("FAIL mid_reset_ctrl: got busy=%b rdy=%b rv=%b expected 0/00/00", bus.busy, bus.req_ready, bus.rsp_valid); end
    tests_run++; if (bus.rsp_data !== 32'h0 || bus.rsp_zero !== 1'b0 || bus.rsp_err !== 1'b0) begin failed++; $display("FAIL mid_reset_data: got d=%h z=%b e=%b expected 0/0/0", bus.rsp_data, bus.rsp_zero, bus.rsp_err); end
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      tests_run++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin failed++; $display("FAIL mid_after%0d: got rv=%b busy=%b expected 00/0", i, bus.rsp_valid, bus.busy); end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    tests_run = 0;
    failed = 0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
    test_reset();
    test_add();
    test_ops();
    test_illegal();
    test_round_robin();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width in bits.
REQ-002 Parameter OP_W, default 4, ALU operation code width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 req_ready  output  2  per-requester accept; transfer when valid&ready high on same edge.
REQ-007 req_a0, req_a1  input  DATA_W each  operand A per requester.
REQ-008 req_b0, req_b1  input  DATA_W each  operand B per requester.
REQ-009 req_op0, req_op1  input  OP_W each  operation code per requester.
REQ-010 rsp_valid  output  2  response valid, one-hot, to the requester that issued it.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_data  output  DATA_W  registered ALU result, shared by both requesters.
REQ-013 rsp_zero  output  1  high when rsp_data equals 0.
REQ-014 rsp_err  output  1  high when the accepted op code was not a legal code.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 Op codes SHALL be: AND 0000, OR 0011, ADD 0010, SUB 0110, SLT 0111; SLT is an unsigned compare giving 1 or 0.
REQ-017 Illegal op code SHALL give result 0, rsp_zero 1, rsp_err 1.
REQ-018 ADD/SUB SHALL wrap modulo 2^DATA_W; no carry or overflow output.
REQ-019 FSM states SHALL be IDLE, EXEC, RESP; IDLE->EXEC on grant; EXEC->RESP always after one cycle; RESP->IDLE when rsp_valid&rsp_ready of the granted requester.
REQ-020 In IDLE, req_ready SHALL be one-hot to the arbitration winner among asserted req_valid bits, and 0 when none is asserted; req_ready SHALL be 0 in EXEC and RESP.
REQ-021 Arbitration SHALL be round-robin: a last-grant pointer is updated on each accepted request; on a tie the requester not last granted wins.
REQ-022 Operands, op code and requester index SHALL be captured on the accept edge; later input changes SHALL have no effect.
REQ-023 Latency: accept at edge N, result registered at edge N+1, rsp_valid high after edge N+2... exactly: rsp_valid SHALL rise after edge N+1 and stay high, with rsp_data/zero/err stable, until rsp_ready.
REQ-024 Only one transaction SHALL be outstanding; no request is accepted in the cycle the response is consumed (next accept at earliest one cycle after the RESP->IDLE edge).
REQ-025 rsp_ready on the non-granted bit SHALL be ignored.

Reset
REQ-026 While rst_n is low: state IDLE, req_ready 0, rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_err 0, busy 0, last-grant pointer selects requester 1 so requester 0 wins the first tie.
REQ-027 Reset asserted mid-transaction SHALL discard it with no response issued.

Configuration
REQ-028 Macro ALU_SHARE_FIXED_PRIO_EN defined: requester 0 SHALL always win ties, and the pointer is unused; undefined: round-robin per REQ-021.

Structure
REQ-029 Package alu_share_pkg SHALL hold the op code constants, the FSM state typedef and the default DATA_W/OP_W.
REQ-030 The combinational operation SHALL be one sub-module alu_core (A, B, op -> result, zero, err); the controller holds all registers.

Verification
REQ-031 Requester 0 only: a0=5, b0=3, op ADD -> accept at edge N; rsp_valid[0] after edge N+1; rsp_data=8, zero=0, err=0.
REQ-032 Both valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1 (with macro: 0,0,0,0); requester 1 never starved without the macro.
REQ-033 SUB 7-7 -> rsp_data=0, rsp_zero=1; SUB 0-1 -> rsp_data=0xFFFFFFFF; SLT 1<0xFFFFFFFF -> 1.
REQ-034 Op 1111 -> rsp_data=0, rsp_zero=1, rsp_err=1.
REQ-035 Hold rsp_ready=0 for 10 cycles with a new req_valid pending -> rsp_valid and data stable, req_ready stays 0, busy=1.
REQ-036 Assert rst_n low during EXEC -> all outputs reset immediately, no rsp_valid after release.
